// File: rtl/instr_encoder_pkg.sv
// Shared instruction field layout and ALU opcodes.
// Used by the encoder here and by the decode stage downstream.
package instr_encoder_pkg;

    localparam int INSTR_W      = 32;

    localparam int DATA_SRC_BIT = 29;
    localparam int ALU_OP_MSB   = 28;
    localparam int ALU_OP_LSB   = 26;
    localparam int WSEL_MSB     = 25;
    localparam int WSEL_LSB     = 21;
    localparam int RSEL1_MSB    = 20;
    localparam int RSEL1_LSB    = 16;
    localparam int RSEL2_MSB    = 15;
    localparam int RSEL2_LSB    = 11;
    localparam int IMM_MSB      = 15;
    localparam int IMM_LSB      = 0;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef enum logic {
        SRC_REG = 1'b0,
        SRC_IMM = 1'b1
    } data_src_e;

endpackage

// File: rtl/instr_fifo.sv
// First-word fall-through FIFO holding packed instruction words.
// Head reads as zero while empty so stale storage never leaks out.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rptr];

    // Storage write; contents are left unreset since empty masks them
    always_ff @(posedge clk) begin
        if (rst && !flush && do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH; flush and reset both clear them
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded field tuples into 32-bit instruction words and
// buffers them for the decode stage behind a valid/ready FIFO.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_data_src,
    input  logic [2:0]             in_alu_op,
    input  logic [4:0]             in_write_sel,
    input  logic [4:0]             in_read_sel1,
    input  logic [4:0]             in_read_sel2,
    input  logic [15:0]            in_immediate,
    output logic [INSTR_W-1:0]     instr_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [CNT_W-1:0]       issued_cnt
);

    logic [INSTR_W-1:0] word;
    logic               push_fire;
    logic               pop_fire;
    logic               full;
    logic               empty;

    // Field packing; the low half is either the immediate or rs2
    always_comb begin
        word = '0;
        word[DATA_SRC_BIT]          = in_data_src;
        word[ALU_OP_MSB:ALU_OP_LSB] = in_alu_op;
        word[WSEL_MSB:WSEL_LSB]     = in_write_sel;
        word[RSEL1_MSB:RSEL1_LSB]   = in_read_sel1;
        if (in_data_src == SRC_IMM) begin
            word[IMM_MSB:IMM_LSB] = in_immediate;
        end else begin
            word[RSEL2_MSB:RSEL2_LSB] = in_read_sel2;
        end
    end

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push_fire = in_valid && in_ready;
    assign pop_fire  = out_valid && out_ready;

    instr_fifo #(
        .DEPTH (DEPTH),
        .DW    (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push_fire),
        .pop   (pop_fire),
        .wdata (word),
        .rdata (instr_out),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    // Count delivered words; a pop cancelled by flush is not counted
    always_ff @(posedge clk) begin
        if (!rst) begin
            issued_cnt <= '0;
        end else if (pop_fire && !flush) begin
            issued_cnt <= issued_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes reference words,
// a monitor pops and compares whenever the DUT hands a word downstream.
module tb_instr_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_data_src = 1'b0;
    logic [2:0]  in_alu_op = '0;
    logic [4:0]  in_write_sel = '0;
    logic [4:0]  in_read_sel1 = '0;
    logic [4:0]  in_read_sel2 = '0;
    logic [15:0] in_immediate = '0;
    logic [31:0] instr_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  occupancy;
    logic [15:0] issued_cnt;

    always #5 clk = ~clk;

    instr_encoder #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data_src  (in_data_src),
        .in_alu_op    (in_alu_op),
        .in_write_sel (in_write_sel),
        .in_read_sel1 (in_read_sel1),
        .in_read_sel2 (in_read_sel2),
        .in_immediate (in_immediate),
        .instr_out    (instr_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .occupancy    (occupancy),
        .issued_cnt   (issued_cnt)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int unsigned model_issued = 0;
    logic        accepted = 1'b0;

    function automatic logic [31:0] ref_word(
        input logic        src,
        input logic [2:0]  op,
        input logic [4:0]  ws,
        input logic [4:0]  r1,
        input logic [4:0]  r2,
        input logic [15:0] imm
    );
        int unsigned w;
        w = int'(op) * 32'h0400_0000
          + int'(ws) * 32'h0020_0000
          + int'(r1) * 32'h0001_0000;
        if (src) w = w + 32'h2000_0000 + int'(imm);
        else     w = w + int'(r2) * 32'h0000_0800;
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every accepted downstream word is compared to the model
    always @(negedge clk) begin
        if (rst === 1'b1 && flush === 1'b0 &&
            out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("pop_with_empty_model", {31'b0, out_valid}, 32'd0);
            end else begin
                check("pop_word", instr_out, exp_q.pop_front());
                model_issued++;
            end
        end
    end

    task automatic state_check();
        int n;
        n = exp_q.size();
        check("occupancy", {29'b0, occupancy}, n);
        check("out_valid", {31'b0, out_valid}, {31'b0, n != 0});
        check("in_ready", {31'b0, in_ready}, {31'b0, n != DEPTH});
        check("issued_cnt", {16'b0, issued_cnt}, model_issued & 32'hFFFF);
        if (n == 0) check("instr_out_empty", instr_out, 32'h0);
        else        check("instr_out_head", instr_out, exp_q[0]);
    endtask

    // One clock: record the handshake as the DUT will see it, then check
    task automatic step(input logic do_check = 1'b1);
        @(negedge clk);
        accepted = 1'b0;
        if (!rst) begin
            exp_q.delete();
            model_issued = 0;
        end else if (flush) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back(ref_word(in_data_src, in_alu_op, in_write_sel,
                                     in_read_sel1, in_read_sel2,
                                     in_immediate));
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
        if (do_check) state_check();
    endtask

    task automatic rand_fields();
        in_data_src  = 1'($urandom);
        in_alu_op    = 3'($urandom);
        in_write_sel = 5'($urandom);
        in_read_sel1 = 5'($urandom);
        in_read_sel2 = 5'($urandom);
        in_immediate = 16'($urandom);
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        check("rst_occupancy", {29'b0, occupancy}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_instr_out", instr_out, 32'h0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_issued", {16'b0, issued_cnt}, 32'd0);
        rst = 1'b1;
    endtask

    task automatic push_n(input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            rand_fields();
            in_valid = 1'b1;
            guard = 0;
            do begin
                step();
                guard++;
            end while (!accepted && guard < 20);
            if (!accepted) check("push_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        in_valid = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            step();
            guard++;
        end
        check("drain_done", {29'b0, occupancy}, 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int unsigned base;

        reset_dut();

        // Immediate-form packing
        in_data_src  = 1'b1;
        in_alu_op    = 3'b010;
        in_write_sel = 5'd5;
        in_read_sel1 = 5'd3;
        in_read_sel2 = 5'd9;
        in_immediate = 16'hBEEF;
        in_valid     = 1'b1;
        step();
        in_valid = 1'b0;
        check("imm_pack", instr_out, 32'h28A3BEEF);
        check("imm_valid", {31'b0, out_valid}, 32'd1);

        // Register-form packing
        reset_dut();
        in_data_src  = 1'b0;
        in_alu_op    = 3'b001;
        in_write_sel = 5'd1;
        in_read_sel1 = 5'd2;
        in_read_sel2 = 5'd4;
        in_immediate = 16'hFFFF;
        in_valid     = 1'b1;
        step();
        in_valid = 1'b0;
        check("reg_pack", instr_out, 32'h04222000);
        drain();

        // Fill and backpressure
        reset_dut();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_fields();
            in_valid = 1'b1;
            step();
            check(i < 4 ? "fill_accept" : "fifth_held",
                  {31'b0, accepted}, {31'b0, i < 4});
        end
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        check("full_occ", {29'b0, occupancy}, 32'd4);
        out_ready = 1'b1;
        step();
        check("ready_after_pop", {31'b0, in_ready}, 32'd1);
        guard = 0;
        while (!accepted && guard < 10) begin
            step();
            guard++;
        end
        check("fifth_accepted", {31'b0, accepted}, 32'd1);
        drain();

        // Steady push/pop at occupancy 2
        reset_dut();
        push_n(2);
        base = model_issued;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_fields();
            step();
            check("steady_occ", {29'b0, occupancy}, 32'd2);
        end
        check("steady_issued", {16'b0, issued_cnt}, (base + 10) & 32'hFFFF);
        drain();

        // Flush with concurrent pop and push, then reset mid-stream
        reset_dut();
        push_n(2);
        drain();
        push_n(3);
        flush = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        rand_fields();
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("flush_occ", {29'b0, occupancy}, 32'd0);
        check("flush_issued", {16'b0, issued_cnt}, 32'd2);
        push_n(2);
        out_ready = 1'b1;
        in_valid = 1'b1;
        rst = 1'b0;
        step();
        check("midrst_occ", {29'b0, occupancy}, 32'd0);
        check("midrst_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_instr", instr_out, 32'h0);
        check("midrst_ready", {31'b0, in_ready}, 32'd1);
        check("midrst_issued", {16'b0, issued_cnt}, 32'd0);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 500; i++) begin
            rand_fields();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 99) != 0);
            step();
        end
        rst = 1'b1;
        flush = 1'b0;
        drain();

        // Counter wrap and long pointer wrap
        reset_dut();
        in_valid = 1'b1;
        out_ready = 1'b1;
        guard = 0;
        while (model_issued < 65535 && guard < 70000) begin
            rand_fields();
            step(1'b0);
            guard++;
        end
        state_check();
        check("near_wrap", {16'b0, issued_cnt}, 32'h0000FFFF);
        rand_fields();
        step();
        rand_fields();
        step();
        check("wrap_issued", {16'b0, issued_cnt}, 32'h00000001);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
